// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its next-PC helper.
package ifetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_npc_calc.sv
// Next-PC adder: pc + 4, plus a sign-extended word offset when the branch is taken.
// Purely combinational; no backpressure.
module npc_calc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [15:0] imm16_i,
  input  logic        npc_sel_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] offset;

  // Word offset to byte offset: sign-extend then shift left by two.
  assign offset    = npc_sel_i ? {{14{imm16_i[15]}}, imm16_i, 2'b00} : 32'd0;
  assign next_pc_o = pc_i + PC_INC + offset;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch FSM: one handshaked imem read per instruction, word held until commit; >=2 cycles/instr.
// Backpressure: holds request until imem_ack and the word until inst_ack; counters under IFETCH_PERF_CNT_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nPC_sel,
  input  logic [15:0] imm16,
  input  logic        inst_ack,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] branch_cnt
`endif
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc;
  logic        commit;

  npc_calc u_npc_calc (
    .pc_i      (pc_q),
    .imm16_i   (imm16),
    .npc_sel_i (nPC_sel),
    .next_pc_o (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    commit  = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (inst_ack) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          commit  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Low address bits are forced clear so pc stays word aligned whatever RESET_PC says.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      inst_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req   = reset_n && (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (commit) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (nPC_sel) branch_cnt_d = branch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_cnt_q  <= 32'd0;
      branch_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign branch_cnt = branch_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, counter sequence, random run vs reference model.
module tb_ifetch_unit;

  logic        clk;
  logic        reset_n;
  logic        nPC_sel;
  logic [15:0] imm16;
  logic        inst_ack;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] branch_cnt;
`endif

  ifetch_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .nPC_sel    (nPC_sel),
    .imm16      (imm16),
    .inst_ack   (inst_ack),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .branch_cnt (branch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One row: inputs applied for a cycle, and the outputs expected during that same cycle.
  typedef struct {
    logic        rst_n;
    logic        mack;
    logic [31:0] rdata;
    logic        iack;
    logic        npc;
    logic [15:0] imm;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        ci;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(logic r, logic ma, logic [31:0] rd, logic ia, logic np, logic [15:0] im,
                              logic er, logic [31:0] ea, logic ev, logic c, logic [31:0] ei);
    vec_t v;
    v.rst_n = r;  v.mack = ma; v.rdata = rd; v.iack = ia; v.npc = np; v.imm = im;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.ci = c; v.e_inst = ei;
    return v;
  endfunction

  task automatic drive(input logic r, input logic ma, input logic [31:0] rd,
                       input logic ia, input logic np, input logic [15:0] im);
    reset_n = r; imem_ack = ma; imem_rdata = rd; inst_ack = ia; nPC_sel = np; imm16 = im;
  endtask

  // Issue one fetch (acked immediately) and commit it; bounded wait for the request.
  task automatic commit_one(input logic np, input logic [15:0] im, input logic [31:0] word);
    bit seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (imem_req) seen = 1;
      else step();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL commit_wait: imem_req never asserted");
    end
    drive(1, 1, word, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, np, im);
    step();
    drive(1, 0, 0, 0, 0, 0);
  endtask

  // Reference model state
  logic [31:0] m_pc, m_inst, m_fcnt, m_bcnt;
  logic        m_valid;

  vec_t vt[$];

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();

    // Directed table: first fetch, sequential commits, branches, wait states, wrap, reset mid-fetch.
    vt.push_back(mk(0,1,32'hDEAD_BEEF,1,1,16'h1234, 0,32'h0,0,1,32'h0));
    vt.push_back(mk(1,0,32'h0,0,0,16'h0,           1,32'h0,0,1,32'h0));
    vt.push_back(mk(1,1,32'h2008_0005,0,0,16'h0,   1,32'h0,0,1,32'h0));
    vt.push_back(mk(1,0,32'h0,0,1,16'h7FFF,        0,32'h0,1,1,32'h2008_0005));
    vt.push_back(mk(1,0,32'h0,1,0,16'h7FFF,        0,32'h0,1,1,32'h2008_0005));
    vt.push_back(mk(1,1,32'hA000_0004,0,0,16'h0,   1,32'h4,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,0,16'h0,           0,32'h4,1,1,32'hA000_0004));
    vt.push_back(mk(1,1,32'hA000_0008,0,0,16'h0,   1,32'h8,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,0,16'h0,           0,32'h8,1,1,32'hA000_0008));
    vt.push_back(mk(1,1,32'hA000_000C,0,0,16'h0,   1,32'hC,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,0,16'h0,           0,32'hC,1,1,32'hA000_000C));
    vt.push_back(mk(1,1,32'hA000_0010,0,0,16'h0,   1,32'h10,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,1,16'h0003,        0,32'h10,1,1,32'hA000_0010));
    vt.push_back(mk(1,1,32'hA000_0020,0,0,16'h0,   1,32'h20,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,1,16'h0003,        0,32'h20,1,1,32'hA000_0020));
    vt.push_back(mk(1,1,32'hA000_0030,0,0,16'h0,   1,32'h30,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,1,16'hFFFB,        0,32'h30,1,1,32'hA000_0030));
    vt.push_back(mk(1,1,32'hA000_0020,0,0,16'h0,   1,32'h20,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,1,16'hFFFF,        0,32'h20,1,1,32'hA000_0020));
    vt.push_back(mk(1,1,32'hA000_0021,0,0,16'h0,   1,32'h20,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,0,16'h8000,        0,32'h20,1,1,32'hA000_0021));
    vt.push_back(mk(1,0,32'h0,1,1,16'h0010,        1,32'h24,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,0,0,16'h0,           1,32'h24,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,0,16'h0,           1,32'h24,0,0,32'h0));
    vt.push_back(mk(1,1,32'hA000_0024,0,0,16'h0,   1,32'h24,0,0,32'h0));
    vt.push_back(mk(1,1,32'h0BAD_0BAD,0,0,16'h0,   0,32'h24,1,1,32'hA000_0024));
    vt.push_back(mk(1,0,32'h0,1,1,16'hFFF5,        0,32'h24,1,1,32'hA000_0024));
    vt.push_back(mk(1,1,32'hA000_00FC,0,0,16'h0,   1,32'hFFFF_FFFC,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,0,16'h0,           0,32'hFFFF_FFFC,1,1,32'hA000_00FC));
    vt.push_back(mk(1,1,32'hA000_0000,0,0,16'h0,   1,32'h0,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,1,0,16'h0,           0,32'h0,1,1,32'hA000_0000));
    vt.push_back(mk(1,0,32'h0,0,0,16'h0,           1,32'h4,0,0,32'h0));
    vt.push_back(mk(0,1,32'h0BAD_F00D,0,0,16'h0,   0,32'h4,0,0,32'h0));
    vt.push_back(mk(1,0,32'h0,0,0,16'h0,           1,32'h0,0,1,32'h0));
    vt.push_back(mk(1,1,32'hA100_0000,0,0,16'h0,   1,32'h0,0,1,32'h0));
    vt.push_back(mk(1,0,32'h0,0,0,16'h0,           0,32'h0,1,1,32'hA100_0000));

    foreach (vt[i]) begin
      drive(vt[i].rst_n, vt[i].mack, vt[i].rdata, vt[i].iack, vt[i].npc, vt[i].imm);
      #1;
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].e_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_pc", i), pc, vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid}, {31'd0, vt[i].e_valid});
      if (vt[i].ci) chk($sformatf("vec%0d_inst", i), inst, vt[i].e_inst);
      step();
    end

    // Long reset with acks present: request must stay low and nothing gets captured.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'hFFFF_0000 + k, 1, 1, 16'h0001);
      #1;
      chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
      step();
      chk("rst_hold_valid", {31'd0, inst_valid}, 32'd0);
    end
    drive(1, 0, 0, 0, 0, 0);

`ifdef IFETCH_PERF_CNT_EN
    // Five commits with two taken branches, then reset clears both counters.
    commit_one(0, 16'h0000, 32'h1);
    commit_one(1, 16'h0002, 32'h2);
    commit_one(0, 16'h0000, 32'h3);
    commit_one(1, 16'hFFFE, 32'h4);
    commit_one(0, 16'h0000, 32'h5);
    chk("perf_fetch_cnt", fetch_cnt, 32'd5);
    chk("perf_branch_cnt", branch_cnt, 32'd2);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("perf_fetch_rst", fetch_cnt, 32'd0);
    chk("perf_branch_rst", branch_cnt, 32'd0);
    drive(1, 0, 0, 0, 0, 0);
`else
    commit_one(1, 16'h0002, 32'h2);
    chk("seq_branch_addr", imem_addr, 32'h0000_000C);
`endif

    // Randomized run against a behavioural model of the fetch rules.
    drive(0, 0, 0, 0, 0, 0);
    step();
    m_pc = 32'd0; m_inst = 32'd0; m_valid = 1'b0; m_fcnt = 32'd0; m_bcnt = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) >= 3), ($urandom_range(0, 2) == 0), $urandom,
            ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, 16'($urandom));
      #1;
      chk("rnd_req", {31'd0, imem_req}, {31'd0, reset_n && !m_valid});
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_valid", {31'd0, inst_valid}, {31'd0, m_valid});
      chk("rnd_inst", inst, m_inst);
`ifdef IFETCH_PERF_CNT_EN
      chk("rnd_fetch_cnt", fetch_cnt, m_fcnt);
      chk("rnd_branch_cnt", branch_cnt, m_bcnt);
`endif
      if (!reset_n) begin
        m_pc = 32'd0; m_inst = 32'd0; m_valid = 1'b0; m_fcnt = 32'd0; m_bcnt = 32'd0;
      end else if (!m_valid && imem_ack) begin
        m_inst  = imem_rdata;
        m_valid = 1'b1;
      end else if (m_valid && inst_ack) begin
        m_pc    = m_pc + 32'd4 + (nPC_sel ? 32'(4 * int'($signed(imm16))) : 32'd0);
        m_valid = 1'b0;
        m_fcnt  = m_fcnt + 32'd1;
        if (nPC_sel) m_bcnt = m_bcnt + 32'd1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
